// File: rtl/y86_pkg.sv
// Shared encodings for the Y86-64 SEQ control slice: controller states,
// architectural status codes and the halt icode.
package y86_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_FETCH  = 3'd1;
  localparam logic [2:0] ST_DECODE = 3'd2;
  localparam logic [2:0] ST_EXEC   = 3'd3;
  localparam logic [2:0] ST_MEM    = 3'd4;
  localparam logic [2:0] ST_WB     = 3'd5;
  localparam logic [2:0] ST_PCUPD  = 3'd6;
  localparam logic [2:0] ST_HALT   = 3'd7;

  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_HLT = 3'd2;
  localparam logic [2:0] STAT_ADR = 3'd3;
  localparam logic [2:0] STAT_INS = 3'd4;

  localparam logic [3:0] IHALT = 4'h0;

  // Active means the clock is spent on an instruction (counted by cycles).
  function automatic logic is_active(input logic [2:0] s);
    return (s != ST_IDLE) && (s != ST_HALT);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; sticks at all-ones.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst || clr)
      q <= '0;
    else if (inc && (q != '1))
      q <= q + W'(1);
  end

endmodule

// File: rtl/seq_stage_controller.sv
// Sequencer for the Y86-64 SEQ datapath: owns the PC, steps six handshaked
// stages per instruction, latches status and halts without stopping sim.
module seq_stage_controller
  import y86_pkg::*;
#(
  parameter int          ADDR_W     = 64,
  parameter logic [63:0] START_PC   = 64'd0,
  parameter int          CNT_W      = 32,
  parameter int unsigned MAX_CYCLES = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic              stage_done,
  input  logic [ADDR_W-1:0] new_PC_address,
  input  logic [3:0]        Ins_Code,
  input  logic              instruction_invalid_check,
  input  logic              imemory_error,
  input  logic              data_memory_error,
  output logic [ADDR_W-1:0] PC_adress,
  output logic [2:0]        stage,
  output logic              stage_start,
  output logic              regfile_we,
  output logic [2:0]        status,
  output logic              halted,
  output logic              watchdog,
  output logic [CNT_W-1:0]  retired,
  output logic [CNT_W-1:0]  cycles
);

  localparam bit              WD_EN  = (MAX_CYCLES != 0);
  localparam logic [CNT_W-1:0] WD_LIM = CNT_W'(WD_EN ? MAX_CYCLES - 1 : 0);

  logic [2:0] state, nxt;
  logic [2:0] status_nxt;
  logic       pc_we, ret_inc, active, wd_hit;

  assign active = is_active(state);
  // cycles still reads the old value here, so LIM-1 means "reaches LIM now"
  assign wd_hit = WD_EN && active && (cycles == WD_LIM);

  always_comb begin
    nxt        = state;
    status_nxt = status;
    pc_we      = 1'b0;
    ret_inc    = 1'b0;
    case (state)
      ST_IDLE:   if (run) nxt = ST_FETCH;
      ST_FETCH:
        if (stage_done) begin
          nxt = ST_DECODE;
          if (imemory_error) begin
            status_nxt = STAT_ADR;
            nxt        = ST_HALT;
          end else if (instruction_invalid_check) begin
            status_nxt = STAT_INS;
            nxt        = ST_HALT;
          end else if (Ins_Code == IHALT) begin
            status_nxt = STAT_HLT;
            ret_inc    = 1'b1;
            nxt        = ST_HALT;
          end
        end
      ST_DECODE: if (stage_done) nxt = ST_EXEC;
      ST_EXEC:   if (stage_done) nxt = ST_MEM;
      ST_MEM:
        if (stage_done) begin
          if (data_memory_error) begin
            status_nxt = STAT_ADR;
            nxt        = ST_HALT;
          end else begin
            nxt = ST_WB;
          end
        end
      ST_WB:     if (stage_done) nxt = ST_PCUPD;
      ST_PCUPD:
        if (stage_done) begin
          pc_we   = 1'b1;
          ret_inc = 1'b1;
          nxt     = run ? ST_FETCH : ST_IDLE;
        end
      ST_HALT:   nxt = ST_HALT;
      default:   nxt = ST_IDLE;
    endcase
    // Watchdog overrides the advance but keeps any error code captured above
    if (wd_hit) begin
      nxt     = ST_HALT;
      pc_we   = 1'b0;
      ret_inc = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      PC_adress   <= ADDR_W'(START_PC);
      status      <= STAT_AOK;
      watchdog    <= 1'b0;
      stage_start <= 1'b0;
    end else begin
      state       <= nxt;
      status      <= status_nxt;
      stage_start <= is_active(nxt) && (nxt != state);
      if (pc_we)  PC_adress <= new_PC_address;
      if (wd_hit) watchdog  <= 1'b1;
    end
  end

  assign stage      = state;
  assign regfile_we = (state == ST_WB);
  assign halted     = (state == ST_HALT);

  sat_counter #(.W(CNT_W)) u_retired (
    .clk (clk),
    .rst (rst),
    .clr (1'b0),
    .inc (ret_inc),
    .q   (retired)
  );

  sat_counter #(.W(CNT_W)) u_cycles (
    .clk (clk),
    .rst (rst),
    .clr (1'b0),
    .inc (active),
    .q   (cycles)
  );

endmodule

// File: tb/tb_seq_stage_controller.sv
// Directed bench: stimulus pushes expected retire/halt snapshots, a monitor
// pops and compares whenever the controller retires or enters HALT.
module tb_seq_stage_controller;
  import y86_pkg::*;

  logic        clk = 1'b0;
  logic        rst, rst_b, run, done, inv, imem, dmem;
  logic [3:0]  ins;
  logic [63:0] step, npc_a, npc_b;

  logic [63:0] pc_a, pc_b;
  logic [2:0]  stage_a, stage_b, status_a, status_b;
  logic        ss_a, ss_b, we_a, we_b, halted_a, halted_b, wd_a, wd_b;
  logic [31:0] ret_a, ret_b, cyc_a, cyc_b;

  int vectors = 0, miscompares = 0;
  int ss_cnt = 0, we_cnt = 0;
  logic cnt_en = 1'b0;

  always #5 clk = ~clk;

  // PC_update stage model: next PC is current PC plus the instruction length
  always_comb npc_a = pc_a + step;
  always_comb npc_b = pc_b + step;

  seq_stage_controller dut_a (
    .clk(clk), .rst(rst), .run(run), .stage_done(done), .new_PC_address(npc_a),
    .Ins_Code(ins), .instruction_invalid_check(inv), .imemory_error(imem),
    .data_memory_error(dmem), .PC_adress(pc_a), .stage(stage_a), .stage_start(ss_a),
    .regfile_we(we_a), .status(status_a), .halted(halted_a), .watchdog(wd_a),
    .retired(ret_a), .cycles(cyc_a)
  );

  seq_stage_controller #(.MAX_CYCLES(10)) dut_b (
    .clk(clk), .rst(rst_b), .run(run), .stage_done(done), .new_PC_address(npc_b),
    .Ins_Code(ins), .instruction_invalid_check(inv), .imemory_error(imem),
    .data_memory_error(dmem), .PC_adress(pc_b), .stage(stage_b), .stage_start(ss_b),
    .regfile_we(we_b), .status(status_b), .halted(halted_b), .watchdog(wd_b),
    .retired(ret_b), .cycles(cyc_b)
  );

  typedef struct {
    logic [63:0] pc;
    logic [2:0]  st;
    logic        hl;
    logic        wd;
    logic [31:0] ret;
    logic [31:0] cyc;
  } exp_t;

  exp_t sb[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic push(input logic [63:0] pc, input logic [2:0] st, input logic hl,
                      input logic wd, input logic [31:0] ret, input logic [31:0] cyc);
    exp_t e;
    e.pc = pc; e.st = st; e.hl = hl; e.wd = wd; e.ret = ret; e.cyc = cyc;
    sb.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
  endtask

  // Monitor: an instruction retires when PCUPD is left; a halt is HALT entry
  logic [2:0] prev_stage = ST_IDLE;
  always @(negedge clk) begin
    exp_t e;
    if ((prev_stage == ST_PCUPD && stage_a != ST_PCUPD) ||
        (prev_stage != ST_HALT && stage_a == ST_HALT)) begin
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_event: stage %0d with no expected entry", stage_a);
      end else begin
        e = sb.pop_front();
        chk("ev_pc", pc_a, e.pc);
        chk("ev_status", 64'(status_a), 64'(e.st));
        chk("ev_halted", 64'(halted_a), 64'(e.hl));
        chk("ev_watchdog", 64'(wd_a), 64'(e.wd));
        chk("ev_retired", 64'(ret_a), 64'(e.ret));
        chk("ev_cycles", 64'(cyc_a), 64'(e.cyc));
      end
    end
    prev_stage = stage_a;
  end

  always @(negedge clk) begin
    if (cnt_en) begin
      ss_cnt += int'(ss_a);
      we_cnt += int'(we_a);
    end
  end

  initial begin
    rst = 1'b1; rst_b = 1'b1; run = 1'b0; done = 1'b1; ins = 4'h2;
    inv = 1'b0; imem = 1'b0; dmem = 1'b0; step = 64'd2;
    tick(2);
    rst = 1'b0;
    chk("rst_pc", pc_a, 64'd0);
    chk("rst_stage", 64'(stage_a), 64'(ST_IDLE));
    chk("rst_status", 64'(status_a), 64'(STAT_AOK));
    chk("rst_halted", 64'(halted_a), 64'd0);
    chk("rst_wd", 64'(wd_a), 64'd0);
    chk("rst_retired", 64'(ret_a), 64'd0);
    chk("rst_cycles", 64'(cyc_a), 64'd0);
    chk("rst_ss", 64'(ss_a), 64'd0);
    chk("rst_we", 64'(we_a), 64'd0);

    // Two single-cycle-stage instructions, run dropped mid second one
    push(64'd2, STAT_AOK, 1'b0, 1'b0, 32'd1, 32'd6);
    push(64'd4, STAT_AOK, 1'b0, 1'b0, 32'd2, 32'd12);
    ss_cnt = 0; we_cnt = 0; cnt_en = 1'b1;
    run = 1'b1;
    tick(8);
    run = 1'b0;
    tick(8);
    cnt_en = 1'b0;
    chk("t1_stage_starts", 64'(ss_cnt), 64'd12);
    chk("t1_regfile_we", 64'(we_cnt), 64'd2);
    chk("t1_idle", 64'(stage_a), 64'(ST_IDLE));
    chk("t1_cycles_idle", 64'(cyc_a), 64'd12);

    // MEMORY stalled for three cycles
    do_reset();
    step = 64'd4;
    push(64'd4, STAT_AOK, 1'b0, 1'b0, 32'd1, 32'd9);
    run = 1'b1;
    tick(1);
    run = 1'b0;
    tick(3);
    chk("t2_mem_entry", 64'(stage_a), 64'(ST_MEM));
    chk("t2_mem_start", 64'(ss_a), 64'd1);
    done = 1'b0;
    tick(1);
    chk("t2_mem_hold", 64'(stage_a), 64'(ST_MEM));
    chk("t2_no_restart", 64'(ss_a), 64'd0);
    tick(2);
    chk("t2_mem_hold3", 64'(stage_a), 64'(ST_MEM));
    done = 1'b1;
    tick(3);
    chk("t2_idle", 64'(stage_a), 64'(ST_IDLE));

    // HALT icode at PC 0x16
    do_reset();
    step = 64'h16;
    push(64'h16, STAT_AOK, 1'b0, 1'b0, 32'd1, 32'd6);
    push(64'h16, STAT_HLT, 1'b1, 1'b0, 32'd2, 32'd7);
    run = 1'b1;
    tick(7);
    ins = IHALT;
    tick(1);
    chk("t3_halted", 64'(halted_a), 64'd1);
    chk("t3_status", 64'(status_a), 64'(STAT_HLT));
    repeat (3) begin
      done = 1'b0; tick(1);
      done = 1'b1; tick(1);
    end
    chk("t3_pc_frozen", pc_a, 64'h16);
    chk("t3_ret_frozen", 64'(ret_a), 64'd2);
    chk("t3_cyc_frozen", 64'(cyc_a), 64'd7);
    chk("t3_no_start", 64'(ss_a), 64'd0);
    run = 1'b0;
    ins = 4'h2;

    // imem error outranks invalid instruction
    do_reset();
    imem = 1'b1; inv = 1'b1;
    push(64'd0, STAT_ADR, 1'b1, 1'b0, 32'd0, 32'd1);
    run = 1'b1;
    tick(2);
    run = 1'b0;
    chk("t4_adr", 64'(status_a), 64'(STAT_ADR));
    imem = 1'b0;
    do_reset();
    push(64'd0, STAT_INS, 1'b1, 1'b0, 32'd0, 32'd1);
    run = 1'b1;
    tick(2);
    run = 1'b0;
    chk("t4_ins", 64'(status_a), 64'(STAT_INS));
    inv = 1'b0;

    // Data-memory error skips WRITEBACK
    do_reset();
    step = 64'd2;
    dmem = 1'b1;
    push(64'd0, STAT_ADR, 1'b1, 1'b0, 32'd0, 32'd4);
    ss_cnt = 0; we_cnt = 0; cnt_en = 1'b1;
    run = 1'b1;
    tick(8);
    run = 1'b0;
    cnt_en = 1'b0;
    chk("t5_no_we", 64'(we_cnt), 64'd0);
    chk("t5_pc", pc_a, 64'd0);
    dmem = 1'b0;

    // Watchdog at 10 active cycles on the second DUT
    ins = 4'h1;
    tick(1);
    rst_b = 1'b0;
    run = 1'b1;
    tick(11);
    chk("t6_wd", 64'(wd_b), 64'd1);
    chk("t6_halted", 64'(halted_b), 64'd1);
    chk("t6_cycles", 64'(cyc_b), 64'd10);
    chk("t6_retired", 64'(ret_b), 64'd1);
    chk("t6_pc", pc_b, 64'd2);
    chk("t6_status", 64'(status_b), 64'(STAT_AOK));
    tick(3);
    chk("t6_cyc_frozen", 64'(cyc_b), 64'd10);
    rst_b = 1'b1;
    tick(1);
    rst_b = 1'b0;
    run = 1'b0;
    chk("t6_rst_pc", pc_b, 64'd0);
    chk("t6_rst_status", 64'(status_b), 64'(STAT_AOK));
    chk("t6_rst_wd", 64'(wd_b), 64'd0);
    chk("t6_rst_cycles", 64'(cyc_b), 64'd0);
    chk("t6_rst_retired", 64'(ret_b), 64'd0);
    chk("t6_rst_halted", 64'(halted_b), 64'd0);

    tick(2);
    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
